// File: rtl/draw_pkg.sv
// Shared types and helpers for the drawing / memory-fill address path.
package draw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

    // Bounds of the legacy fixed fill sweep.
    localparam int unsigned SWEEP_START = 3328;
    localparam int unsigned SWEEP_END   = 3456;

    // Lane address is {idx, lane}: a shift and OR, with no carry chain.
    function automatic logic [31:0] lane_addr(input logic [31:0] idx,
                                              input int unsigned lane,
                                              input int unsigned lane_bits);
        return (idx << lane_bits) | lane;
    endfunction

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep controller: IDLE/RUN FSM, index register, latched bounds and status pulses.
module sweep_ctrl
    import draw_pkg::*;
#(
    parameter int IDX_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] start_idx,
    input  logic [IDX_W-1:0] end_idx,
    input  logic             wrap_mode,
    input  logic             abort,
    input  logic             ready,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic             error
);

    sweep_state_t     state, state_n;
    logic [IDX_W-1:0] idx_n;
    logic [IDX_W-1:0] start_l, start_l_n;
    logic [IDX_W-1:0] end_l, end_l_n;
    logic             mode_l, mode_l_n;
    logic             done_n, wrapped_n, error_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            start_l <= '0;
            end_l   <= '0;
            mode_l  <= 1'b0;
            done    <= 1'b0;
            wrapped <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            start_l <= start_l_n;
            end_l   <= end_l_n;
            mode_l  <= mode_l_n;
            done    <= done_n;
            wrapped <= wrapped_n;
            error   <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        start_l_n = start_l;
        end_l_n   = end_l;
        mode_l_n  = mode_l;
        done_n    = 1'b0;
        wrapped_n = 1'b0;
        error_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_idx <= end_idx) begin
                        start_l_n = start_idx;
                        end_l_n   = end_idx;
                        mode_l_n  = wrap_mode;
                        idx_n     = start_idx;
                        state_n   = RUN;
                    end else begin
                        error_n = 1'b1;
                    end
                end
            end
            RUN: begin
                // Abort wins over a same-cycle handshake and suppresses status pulses.
                if (abort) begin
                    state_n = IDLE;
                end else if (ready) begin
                    if (idx == end_l) begin
                        if (mode_l) begin
                            idx_n     = start_l;
                            wrapped_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign valid = (state == RUN);
    assign busy  = (state == RUN);

endmodule

// File: rtl/addr_sweep_gen.sv
// Multi-lane address sweep generator: each beat presents LANES addresses {idx, lane}.
module addr_sweep_gen
    import draw_pkg::*;
#(
    parameter  int ADDR_W = 14,
    parameter  int LANES  = 2,
    localparam int IDX_W  = ADDR_W - $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IDX_W-1:0]        start_idx,
    input  logic [IDX_W-1:0]        end_idx,
    input  logic                    wrap_mode,
    input  logic                    abort,
    input  logic                    ready,
    output logic                    valid,
    output logic [LANES*ADDR_W-1:0] addr,
    output logic                    busy,
    output logic                    done,
    output logic                    wrapped,
    output logic                    error
);

    localparam int unsigned LANE_BITS = $clog2(LANES);

    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;

    sweep_ctrl #(
        .IDX_W(IDX_W)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .start_idx(start_idx),
        .end_idx  (end_idx),
        .wrap_mode(wrap_mode),
        .abort    (abort),
        .ready    (ready),
        .idx      (idx),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped),
        .error    (error)
    );

    assign idx_ext = {{(32-IDX_W){1'b0}}, idx};

    // Addresses are forced to zero outside RUN so the bus is quiet when idle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] full;
        assign full = lane_addr(idx_ext, k, LANE_BITS);
        assign addr[k*ADDR_W +: ADDR_W] = valid ? full[ADDR_W-1:0] : '0;
    end

endmodule

// File: tb/tb_addr_sweep_gen.sv
// Directed self-checking bench for addr_sweep_gen (ADDR_W=14, LANES=2).
module tb_addr_sweep_gen;

    localparam int AW    = 14;
    localparam int IW    = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] end_idx;
    logic          wrap_mode;
    logic          abort;
    logic          ready;
    logic          valid;
    logic [2*AW-1:0] addr;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic          error;

    int checks   = 0;
    int failures = 0;

    addr_sweep_gen #(
        .ADDR_W(14),
        .LANES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .start_idx(start_idx),
        .end_idx  (end_idx),
        .wrap_mode(wrap_mode),
        .abort    (abort),
        .ready    (ready),
        .valid    (valid),
        .addr     (addr),
        .busy     (busy),
        .done     (done),
        .wrapped  (wrapped),
        .error    (error)
    );

    always #5 clk = ~clk;

    wire [AW-1:0] lane0 = addr[AW-1:0];
    wire [AW-1:0] lane1 = addr[2*AW-1:AW];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int s, input int e, input logic w);
        start_idx = IW'(s);
        end_idx   = IW'(e);
        wrap_mode = w;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_idx = '0; end_idx = '0;
        wrap_mode = 1'b0; abort = 1'b0; ready = 1'b0;
        step(); step();
        checks++; if (valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (addr !== '0)      begin failures++; $display("FAIL reset_addr got=%0h exp=0", addr); end
        checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
        checks++; if (error !== 1'b0)   begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        int beats = 0;
        int cyc   = 0;
        int exp_i = 3328;
        ready = 1'b1;
        launch(3328, 3456, 1'b0);
        checks++; if (lane0 !== 14'd6656 || lane1 !== 14'd6657)
            begin failures++; $display("FAIL oneshot_first got=%0d/%0d exp=6656/6657", lane0, lane1); end
        while (valid === 1'b1 && cyc < 200) begin
            checks++; if (lane0 !== AW'(exp_i*2) || lane1 !== AW'(exp_i*2+1) || done !== 1'b0)
                begin failures++; $display("FAIL oneshot_beat got=%0d/%0d done=%b exp=%0d/%0d", lane0, lane1, done, exp_i*2, exp_i*2+1); end
            if (exp_i == 3456) begin
                checks++; if (lane0 !== 14'd6912 || lane1 !== 14'd6913)
                    begin failures++; $display("FAIL oneshot_last got=%0d/%0d exp=6912/6913", lane0, lane1); end
            end
            beats++; exp_i++; cyc++;
            step();
        end
        checks++; if (beats != 129) begin failures++; $display("FAIL oneshot_count got=%0d exp=129", beats); end
        checks++; if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL oneshot_done got done=%b valid=%b busy=%b exp=1/0/0", done, valid, busy); end
        step();
        checks++; if (done !== 1'b0 || valid !== 1'b0)
            begin failures++; $display("FAIL oneshot_after got done=%b valid=%b exp=0/0", done, valid); end
    endtask

    task automatic test_ready_toggle();
        int beats = 0;
        int cyc   = 0;
        int exp_i = 3328;
        launch(3328, 3456, 1'b0);
        while (beats < 129 && cyc < 1000) begin
            checks++; if (valid !== 1'b1 || lane0 !== AW'(exp_i*2) || lane1 !== AW'(exp_i*2+1) || done !== 1'b0)
                begin failures++; $display("FAIL toggle_beat cyc=%0d got=%b %0d/%0d exp=1 %0d/%0d", cyc, valid, lane0, lane1, exp_i*2, exp_i*2+1); end
            ready = (cyc % 3 == 0);
            if (ready) begin beats++; exp_i++; end
            cyc++;
            step();
        end
        ready = 1'b1;
        checks++; if (beats != 129) begin failures++; $display("FAIL toggle_count got=%0d exp=129", beats); end
        checks++; if (done !== 1'b1 || valid !== 1'b0)
            begin failures++; $display("FAIL toggle_done got done=%b valid=%b exp=1/0", done, valid); end
        step();
    endtask

    task automatic test_wrap();
        int exp_i;
        ready = 1'b1;
        launch(5, 7, 1'b1);
        for (int i = 0; i < 7; i++) begin
            exp_i = 5 + (i % 3);
            checks++; if (valid !== 1'b1 || lane0 !== AW'(exp_i*2) || lane1 !== AW'(exp_i*2+1))
                begin failures++; $display("FAIL wrap_beat i=%0d got=%b %0d/%0d exp=1 %0d/%0d", i, valid, lane0, lane1, exp_i*2, exp_i*2+1); end
            checks++; if (wrapped !== ((i == 3) || (i == 6)) || done !== 1'b0)
                begin failures++; $display("FAIL wrap_pulse i=%0d got wrapped=%b done=%b exp=%b/0", i, wrapped, done, (i == 3) || (i == 6)); end
            if (i == 6) abort = 1'b1;
            step();
        end
        abort = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0)
            begin failures++; $display("FAIL wrap_abort got v=%b b=%b d=%b w=%b exp=0000", valid, busy, done, wrapped); end
        step();
    endtask

    task automatic test_error();
        launch(10, 4, 1'b0);
        checks++; if (error !== 1'b1 || valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL error_pulse got e=%b v=%b b=%b exp=1/0/0", error, valid, busy); end
        step();
        checks++; if (error !== 1'b0 || valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL error_after got e=%b v=%b b=%b exp=0/0/0", error, valid, busy); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        launch(3328, 3456, 1'b0);
        for (int i = 0; i < 72; i++) step();
        checks++; if (lane0 !== 14'd6800 || valid !== 1'b1)
            begin failures++; $display("FAIL midreset_pos got=%0d v=%b exp=6800 1", lane0, valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || addr !== '0 || done !== 1'b0 || wrapped !== 1'b0 || error !== 1'b0)
            begin failures++; $display("FAIL midreset_outs got v=%b b=%b a=%0h d=%b w=%b e=%b exp=all 0", valid, busy, addr, done, wrapped, error); end
        step();
        reset = 1'b0;
        step();
        checks++; if (done !== 1'b0 || valid !== 1'b0)
            begin failures++; $display("FAIL midreset_nodone got d=%b v=%b exp=0/0", done, valid); end
        launch(0, 0, 1'b0);
        checks++; if (valid !== 1'b1 || lane0 !== 14'd0 || lane1 !== 14'd1)
            begin failures++; $display("FAIL single_beat got v=%b %0d/%0d exp=1 0/1", valid, lane0, lane1); end
        step();
        checks++; if (valid !== 1'b0 || done !== 1'b1)
            begin failures++; $display("FAIL single_done got v=%b d=%b exp=0/1", valid, done); end
        step();
    endtask

    task automatic test_abort();
        ready = 1'b1;
        launch(3328, 3456, 1'b0);
        start_idx = IW'(10);
        end_idx   = IW'(4);
        start     = 1'b1;
        step();
        start     = 1'b0;
        checks++; if (error !== 1'b0 || valid !== 1'b1 || lane0 !== 14'd6658)
            begin failures++; $display("FAIL run_start_ignored got e=%b v=%b a=%0d exp=0 1 6658", error, valid, lane0); end
        for (int i = 0; i < 21; i++) step();
        checks++; if (lane0 !== 14'd6700 || valid !== 1'b1)
            begin failures++; $display("FAIL abort_pos got=%0d v=%b exp=6700 1", lane0, valid); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0)
            begin failures++; $display("FAIL abort_stop got v=%b b=%b d=%b w=%b exp=0000", valid, busy, done, wrapped); end
        step();
        checks++; if (valid !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL abort_after got v=%b d=%b exp=0/0", valid, done); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_ready_toggle();
        test_wrap();
        test_error();
        test_reset_mid();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
